// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC sequencer:
//   - default widths for the sequencer parameters
//   - per-router / per-source op codes
//   - the sequencer FSM state encoding
//   - a helper that tells whether a state counts as "busy"
// -----------------------------------------------------------------------------
package noc_pkg;

  // Default widths used when the sequencer is instantiated without overrides
  localparam int NUM_ROUTERS_DEF = 16;
  localparam int ROUTER_BITS_DEF = 4;
  localparam int OP_W_DEF        = 4;
  localparam int TCNT_W_DEF      = 8;
  localparam int MCYC_W_DEF      = 16;

  // Op codes shared by routers and traffic sources. They are kept as plain
  // integers so each user can size them to its own OP_W.
  localparam int unsigned OP_NOP          = 0;
  localparam int unsigned OP_INIT         = 1;
  localparam int unsigned OP_LOAD_RT      = 2;
  localparam int unsigned OP_LOAD_STAGING = 3;
  localparam int unsigned OP_PHASE0       = 4;
  localparam int unsigned OP_PHASE1       = 5;
  localparam int unsigned OP_FILL         = 6;
  localparam int unsigned OP_DEQUEUE      = 7;

  // Sequencer FSM states
  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_INIT_TRAFFIC = 4'd1,
    ST_FILL_TRAFFIC = 4'd2,
    ST_INIT_ROUTER  = 4'd3,
    ST_LOAD_RT      = 4'd4,
    ST_LOAD_STAGING = 4'd5,
    ST_PHASE0       = 4'd6,
    ST_PHASE1       = 4'd7,
    ST_HOLD         = 4'd8,
    ST_DONE         = 4'd9
  } noc_state_e;

  // A run is in progress in every state except IDLE and DONE
  function automatic logic state_is_busy(input noc_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/noc_fill_counter.sv
// -----------------------------------------------------------------------------
// noc_fill_counter
// Remaining-packet counter for one traffic source. Loaded with the source's
// packet count when a run starts, decremented once per fill cycle while it is
// still nonzero.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset (count -> 0)
//   load_i      load load_val_i (has priority over decrement)
//   load_val_i  packet count to load
//   dec_i       decrement request; ignored once the count reaches zero
//   nonzero_o   count is still above zero
// -----------------------------------------------------------------------------
module noc_fill_counter #(
  parameter int TCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [TCNT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              nonzero_o
);

  logic [TCNT_W-1:0] count_q;
  logic [TCNT_W-1:0] count_d;

  // Load wins over decrement; the counter saturates at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/noc_sequencer.sv
// -----------------------------------------------------------------------------
// noc_sequencer
// Drives a whole NoC through traffic init, traffic fill, router init and
// routing-table load, then loops LoadStaging / Phase0 / Phase1 until the
// network drains or the cycle limit is reached. Every router and traffic
// source gets its own op each clock.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a run (only accepted in IDLE or DONE)
//   pause           hold at the next Phase1 boundary
//   cfg_max_cycle   network-cycle limit, 0 = unlimited
//   traffic_count   packets per source, TCNT_W bits each, sampled on start
//   rt_valid        per source: table entry exists for the current rt_dst
//   inject_ok       per router: head of traffic i may be injected
//   router_done     per router: idle / empty
//   traffic_empty   per source: queue empty
//   router_op       per-router op, OP_W bits each
//   traffic_op      per-source op, OP_W bits each
//   rt_dst          destination whose table entries are being loaded
//   fill_idx        traffic index currently being filled
//   in_cycle        completed network cycles
//   busy            a run is in progress
//   finished        run ended by draining (sticky until next start)
//   timeout         run ended by the cycle limit (sticky until next start)
//
// State and status outputs come straight from flops. The ops are decoded from
// the registered state in the same cycle, so the op for a state appears while
// the FSM sits in that state; LoadRt and Dequeue are additionally gated by the
// rt_valid / inject_ok answers for that same cycle.
// -----------------------------------------------------------------------------
module noc_sequencer
  import noc_pkg::*;
#(
  parameter int NUM_ROUTERS = NUM_ROUTERS_DEF,
  parameter int ROUTER_BITS = ROUTER_BITS_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int TCNT_W      = TCNT_W_DEF,
  parameter int MCYC_W      = MCYC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pause,
  input  logic [MCYC_W-1:0]             cfg_max_cycle,
  input  logic [NUM_ROUTERS*TCNT_W-1:0] traffic_count,
  input  logic [NUM_ROUTERS-1:0]        rt_valid,
  input  logic [NUM_ROUTERS-1:0]        inject_ok,
  input  logic [NUM_ROUTERS-1:0]        router_done,
  input  logic [NUM_ROUTERS-1:0]        traffic_empty,
  output logic [NUM_ROUTERS*OP_W-1:0]   router_op,
  output logic [NUM_ROUTERS*OP_W-1:0]   traffic_op,
  output logic [ROUTER_BITS-1:0]        rt_dst,
  output logic [TCNT_W-1:0]             fill_idx,
  output logic [MCYC_W-1:0]             in_cycle,
  output logic                          busy,
  output logic                          finished,
  output logic                          timeout
);

  localparam logic [ROUTER_BITS-1:0] RT_LAST = ROUTER_BITS'(NUM_ROUTERS - 1);

  noc_state_e        state_q, state_d;
  logic [ROUTER_BITS-1:0] rt_dst_q, rt_dst_d;
  logic [TCNT_W-1:0] fill_idx_q, fill_idx_d;
  logic [MCYC_W-1:0] in_cycle_q, in_cycle_d;
  logic              busy_q;
  logic              finished_q, finished_d;
  logic              timeout_q, timeout_d;

  logic                   start_ok;
  logic                   filling;
  logic [NUM_ROUTERS-1:0] fill_nonzero;
  logic                   any_fill;
  logic                   drained;
  logic [MCYC_W-1:0]      next_cycle;
  logic                   hit_max;

  logic [NUM_ROUTERS*OP_W-1:0] router_op_c;
  logic [NUM_ROUTERS*OP_W-1:0] traffic_op_c;

  // A start is only honoured when no run is active
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign filling  = (state_q == ST_FILL_TRAFFIC);

  // One remaining-packet counter per traffic source
  for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_fill
    noc_fill_counter #(
      .TCNT_W (TCNT_W)
    ) u_fill (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (start_ok),
      .load_val_i (traffic_count[g*TCNT_W +: TCNT_W]),
      .dec_i      (filling),
      .nonzero_o  (fill_nonzero[g])
    );
  end

  assign any_fill   = |fill_nonzero;
  assign drained    = (&router_done) && (&traffic_empty);
  assign next_cycle = in_cycle_q + 1'b1;
  // A zero limit means run forever; the counter then simply wraps
  assign hit_max    = (cfg_max_cycle != '0) && (next_cycle == cfg_max_cycle);

  // Next-state logic. In Phase1 the cycle limit beats drain, which beats pause.
  always_comb begin
    state_d    = state_q;
    rt_dst_d   = rt_dst_q;
    fill_idx_d = fill_idx_q;
    in_cycle_d = in_cycle_q;
    finished_d = finished_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_INIT_TRAFFIC;
          rt_dst_d   = '0;
          fill_idx_d = '0;
          in_cycle_d = '0;
          finished_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_INIT_TRAFFIC: state_d = ST_FILL_TRAFFIC;
      ST_FILL_TRAFFIC: begin
        // The cycle in which nothing is left to fill is spent idle
        if (any_fill) begin
          fill_idx_d = fill_idx_q + 1'b1;
        end else begin
          state_d = ST_INIT_ROUTER;
        end
      end
      ST_INIT_ROUTER: state_d = ST_LOAD_RT;
      ST_LOAD_RT: begin
        // rt_dst parks on the last destination once the table load is done
        if (rt_dst_q == RT_LAST) begin
          state_d = ST_LOAD_STAGING;
        end else begin
          rt_dst_d = rt_dst_q + 1'b1;
        end
      end
      ST_LOAD_STAGING: state_d = ST_PHASE0;
      ST_PHASE0:       state_d = ST_PHASE1;
      ST_PHASE1: begin
        in_cycle_d = next_cycle;
        if (hit_max) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (drained) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_LOAD_STAGING;
        end
      end
      ST_HOLD: begin
        if (!pause) begin
          state_d = ST_LOAD_STAGING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rt_dst_q   <= '0;
      fill_idx_q <= '0;
      in_cycle_q <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rt_dst_q   <= rt_dst_d;
      fill_idx_q <= fill_idx_d;
      in_cycle_q <= in_cycle_d;
      busy_q     <= state_is_busy(state_d);
      finished_q <= finished_d;
      timeout_q  <= timeout_d;
    end
  end

  // Per-router / per-source op decode for the current state
  always_comb begin
    router_op_c  = '0;
    traffic_op_c = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      case (state_q)
        ST_INIT_TRAFFIC: traffic_op_c[i*OP_W +: OP_W] = OP_W'(OP_INIT);
        ST_FILL_TRAFFIC: begin
          if (fill_nonzero[i]) begin
            traffic_op_c[i*OP_W +: OP_W] = OP_W'(OP_FILL);
          end
        end
        ST_INIT_ROUTER: router_op_c[i*OP_W +: OP_W] = OP_W'(OP_INIT);
        ST_LOAD_RT: begin
          if (rt_valid[i]) begin
            router_op_c[i*OP_W +: OP_W] = OP_W'(OP_LOAD_RT);
          end
        end
        ST_LOAD_STAGING: begin
          router_op_c[i*OP_W +: OP_W] = OP_W'(OP_LOAD_STAGING);
          if (inject_ok[i]) begin
            traffic_op_c[i*OP_W +: OP_W] = OP_W'(OP_DEQUEUE);
          end
        end
        ST_PHASE0: router_op_c[i*OP_W +: OP_W] = OP_W'(OP_PHASE0);
        ST_PHASE1: router_op_c[i*OP_W +: OP_W] = OP_W'(OP_PHASE1);
        default: begin
          router_op_c[i*OP_W +: OP_W]  = OP_W'(OP_NOP);
          traffic_op_c[i*OP_W +: OP_W] = OP_W'(OP_NOP);
        end
      endcase
    end
  end

  assign router_op  = router_op_c;
  assign traffic_op = traffic_op_c;
  assign rt_dst     = rt_dst_q;
  assign fill_idx   = fill_idx_q;
  assign in_cycle   = in_cycle_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_noc_sequencer
// Self-checking bench for noc_sequencer with four routers. Each run is first
// turned into a list of expected clock cycles (inputs to apply plus the
// outputs required in that cycle), built from the sequencing rules with plain
// loops, and then played against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_noc_sequencer;

  localparam int N = 4;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] INI = 4'd1;
  localparam logic [3:0] LRT = 4'd2;
  localparam logic [3:0] LST = 4'd3;
  localparam logic [3:0] PH0 = 4'd4;
  localparam logic [3:0] PH1 = 4'd5;
  localparam logic [3:0] FIL = 4'd6;
  localparam logic [3:0] DEQ = 4'd7;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pause;
  logic [15:0] cfgMax;
  logic [31:0] trafficCount;
  logic [3:0]  rtValid;
  logic [3:0]  injectOk;
  logic [3:0]  routerDone;
  logic [3:0]  trafficEmpty;
  logic [15:0] routerOp;
  logic [15:0] trafficOp;
  logic [1:0]  rtDst;
  logic [7:0]  fillIdx;
  logic [15:0] inCycle;
  logic        busy;
  logic        finished;
  logic        timeout;

  int nAsserts = 0;
  int nFail    = 0;

  // One expected clock cycle: inputs to drive and outputs required
  typedef struct {
    logic        pause;
    logic        drain;
    logic        start;
    logic [15:0] rop;
    logic [15:0] top;
    logic [1:0]  rt;
    logic [7:0]  fi;
    logic [15:0] ic;
    logic        busy;
    logic        fin;
    logic        to;
  } rec_t;

  rec_t trace[$];
  int   loadRtIdx;

  noc_sequencer #(
    .NUM_ROUTERS (4),
    .ROUTER_BITS (2),
    .OP_W        (4),
    .TCNT_W      (8),
    .MCYC_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .cfg_max_cycle (cfgMax),
    .traffic_count (trafficCount),
    .rt_valid      (rtValid),
    .inject_ok     (injectOk),
    .router_done   (routerDone),
    .traffic_empty (trafficEmpty),
    .router_op     (routerOp),
    .traffic_op    (trafficOp),
    .rt_dst        (rtDst),
    .fill_idx      (fillIdx),
    .in_cycle      (inCycle),
    .busy          (busy),
    .finished      (finished),
    .timeout       (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] allOps(input logic [3:0] op);
    return {4{op}};
  endfunction

  function automatic logic [15:0] maskOps(input logic [3:0] op, input logic [3:0] m);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m[i]) v[i*4 +: 4] = op;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushRec(input logic p, input logic d, input logic [15:0] rop,
                         input logic [15:0] top, input int rt, input int fi,
                         input int ic, input logic bsy, input logic fin, input logic to);
    rec_t r;
    r.pause = p;
    r.drain = d;
    r.start = bsy ? ($urandom_range(0, 3) == 0) : 1'b0;
    r.rop   = rop;
    r.top   = top;
    r.rt    = 2'(rt);
    r.fi    = 8'(fi);
    r.ic    = 16'(ic);
    r.busy  = bsy;
    r.fin   = fin;
    r.to    = to;
    trace.push_back(r);
  endtask

  // Expected cycle list for one run, from the sequencing rules
  task automatic buildRun(input logic [31:0] cnts, input logic [3:0] rv, input logic [3:0] iok,
                          input int maxc, input int drainFrom, input int pauseAt, input int pauseLen);
    int         rem[N];
    int         fi;
    int         c;
    logic [3:0] m;
    logic       d;
    logic       pz;
    logic       endTo;
    logic       endFin;
    trace.delete();
    fi = 0;
    for (int i = 0; i < N; i++) rem[i] = int'(cnts[i*8 +: 8]);
    pushRec(1'b0, 1'b0, '0, allOps(INI), 0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) m[i] = (rem[i] > 0);
      pushRec(1'b0, 1'b0, '0, maskOps(FIL, m), 0, fi, 0, 1'b1, 1'b0, 1'b0);
      if (m == 4'b0) break;
      for (int i = 0; i < N; i++) if (rem[i] > 0) rem[i]--;
      fi++;
    end
    pushRec(1'b0, 1'b0, allOps(INI), '0, 0, fi, 0, 1'b1, 1'b0, 1'b0);
    loadRtIdx = trace.size();
    for (int k = 0; k < N; k++)
      pushRec(1'b0, 1'b0, maskOps(LRT, rv), '0, k, fi, 0, 1'b1, 1'b0, 1'b0);
    endTo  = 1'b0;
    endFin = 1'b0;
    c = 0;
    while (c < 64) begin
      d  = (c >= drainFrom);
      pz = (c == pauseAt);
      pushRec(1'($urandom_range(0, 1)), d, allOps(LST), maskOps(DEQ, iok), N-1, fi, c, 1'b1, 1'b0, 1'b0);
      pushRec(1'($urandom_range(0, 1)), d, allOps(PH0), '0, N-1, fi, c, 1'b1, 1'b0, 1'b0);
      pushRec(pz, d, allOps(PH1), '0, N-1, fi, c, 1'b1, 1'b0, 1'b0);
      if ((maxc != 0) && (c + 1 == maxc)) begin
        endTo = 1'b1;
        break;
      end else if (d) begin
        endFin = 1'b1;
        break;
      end else if (pz) begin
        for (int j = 0; j < pauseLen; j++)
          pushRec(j < pauseLen - 1, d, '0, '0, N-1, fi, c + 1, 1'b1, 1'b0, 1'b0);
      end
      c++;
    end
    pushRec(1'b0, 1'b0, '0, '0, N-1, fi, c + 1, 1'b0, endFin, endTo);
    pushRec(1'b0, 1'b0, '0, '0, N-1, fi, c + 1, 1'b0, endFin, endTo);
  endtask

  task automatic checkRec(input rec_t r, input int idx);
    cmp($sformatf("router_op@%0d", idx), {16'b0, routerOp}, {16'b0, r.rop});
    cmp($sformatf("traffic_op@%0d", idx), {16'b0, trafficOp}, {16'b0, r.top});
    cmp($sformatf("rt_dst@%0d", idx), {30'b0, rtDst}, {30'b0, r.rt});
    cmp($sformatf("fill_idx@%0d", idx), {24'b0, fillIdx}, {24'b0, r.fi});
    cmp($sformatf("in_cycle@%0d", idx), {16'b0, inCycle}, {16'b0, r.ic});
    cmp($sformatf("busy@%0d", idx), {31'b0, busy}, {31'b0, r.busy});
    cmp($sformatf("finished@%0d", idx), {31'b0, finished}, {31'b0, r.fin});
    cmp($sformatf("timeout@%0d", idx), {31'b0, timeout}, {31'b0, r.to});
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_router_op"}, {16'b0, routerOp}, 32'h0);
    cmp({tag, "_traffic_op"}, {16'b0, trafficOp}, 32'h0);
    cmp({tag, "_rt_dst"}, {30'b0, rtDst}, 32'h0);
    cmp({tag, "_fill_idx"}, {24'b0, fillIdx}, 32'h0);
    cmp({tag, "_in_cycle"}, {16'b0, inCycle}, 32'h0);
    cmp({tag, "_busy"}, {31'b0, busy}, 32'h0);
    cmp({tag, "_finished"}, {31'b0, finished}, 32'h0);
    cmp({tag, "_timeout"}, {31'b0, timeout}, 32'h0);
  endtask

  // Drive the inputs of one expected cycle, check it, then advance a clock
  task automatic applyStimulus(input int upto);
    rec_t r;
    for (int idx = 0; idx < upto && idx < trace.size(); idx++) begin
      r = trace[idx];
      pause        = r.pause;
      start        = r.start;
      trafficCount = $urandom;
      if (r.drain) begin
        routerDone   = 4'hF;
        trafficEmpty = 4'hF;
      end else begin
        routerDone   = 4'($urandom);
        trafficEmpty = 4'($urandom);
        routerDone[$urandom_range(0, 3)] = 1'b0;
      end
      #1;
      checkRec(r, idx);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  // Issue start from IDLE/DONE with the run's configuration
  task automatic launch(input logic [31:0] cnts, input logic [3:0] rv, input logic [3:0] iok,
                        input int maxc);
    rtValid      = rv;
    injectOk     = iok;
    cfgMax       = 16'(maxc);
    trafficCount = cnts;
    pause        = 1'($urandom);
    routerDone   = 4'($urandom);
    trafficEmpty = 4'($urandom);
    start        = 1'b1;
    #1;
    cmp("launch_busy", {31'b0, busy}, 32'h0);
    cmp("launch_router_op", {16'b0, routerOp}, 32'h0);
    cmp("launch_traffic_op", {16'b0, trafficOp}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input logic [31:0] cnts, input logic [3:0] rv, input logic [3:0] iok,
                             input int maxc, input int drainFrom, input int pauseAt, input int pauseLen);
    buildRun(cnts, rv, iok, maxc, drainFrom, pauseAt, pauseLen);
    launch(cnts, rv, iok, maxc);
    applyStimulus(trace.size());
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pause        = 1'b0;
    cfgMax       = '0;
    trafficCount = '0;
    rtValid      = '0;
    injectOk     = '0;
    routerDone   = '0;
    trafficEmpty = '0;
    #3;
    checkReset("reset");
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkReset("idle");

    $display("[TB] fill {2,0,1,3}, rt_valid 1010, limit 5 cycles");
    checkOutput({8'd3, 8'd1, 8'd0, 8'd2}, 4'b1010, 4'b0110, 5, 1000, -1, 1);

    $display("[TB] reset clears sticky timeout");
    rst = 1'b1;
    #1;
    checkReset("sticky_rst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] zero counts, unlimited, drain in third cycle");
    checkOutput(32'h0, 4'b0101, 4'b1111, 0, 2, -1, 1);

    $display("[TB] pause during Phase1 of cycle 2 held 4 clocks");
    checkOutput({8'd1, 8'd2, 8'd1, 8'd0}, 4'b1111, 4'b1001, 0, 4, 1, 4);

    $display("[TB] limit and drain in the same Phase1");
    checkOutput({8'd0, 8'd0, 8'd1, 8'd0}, 4'b0011, 4'b0000, 2, 1, -1, 1);

    $display("[TB] reset in the middle of the table load");
    buildRun({8'd1, 8'd0, 8'd2, 8'd1}, 4'b0110, 4'b1100, 0, 3, -1, 1);
    launch({8'd1, 8'd0, 8'd2, 8'd1}, 4'b0110, 4'b1100, 0);
    applyStimulus(loadRtIdx + 2);
    rst = 1'b1;
    #1;
    checkReset("midrun_rst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkReset("after_rst");

    $display("[TB] randomized runs");
    for (int k = 0; k < 12; k++) begin
      logic [31:0] cnts;
      for (int i = 0; i < N; i++) cnts[i*8 +: 8] = 8'($urandom_range(0, 4));
      checkOutput(cnts, 4'($urandom), 4'($urandom), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 4)) - 1,
                  int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
